seq_detect_ctrl: RTL and testbench
==================================

// Module: seq_detect_ctrl
// PURPOSE
//   Session controller around a serial pattern matcher. Programs a PAT_W-bit pattern and arms a
//   detection session. Streams bits through a history register and reports each match over a
//   valid/ready handshake. Ends the session after MAX_MATCH matches or MAX_BITS input bits.
//   Sits between the serial bit source and the consumer of match events in the seq_detect fabric.
// PARAMETERS
//   PAT_W      4    pattern length in bits (>=2)
//   MAX_BITS   256  bit budget per session; exhausting it ends the session with timeout
//   MAX_MATCH  8    matches per session before normal completion (>=1)
//   CNT_W = $clog2(MAX_BITS+1), MC_W = $clog2(MAX_MATCH+1)  (derived localparams)
// PORTS
//   clk          in   1      single clock, all state on posedge
//   rst_n        in   1      asynchronous, active-low reset
//   cfg_we       in   1      load cfg_pattern; honoured in IDLE only
//   cfg_pattern  in   PAT_W  pattern; MSB is the oldest bit
//   start        in   1      begin session (IDLE or DONE)
//   abort        in   1      kill session from any state
//   in_valid     in   1      in_bit valid this cycle
//   in_bit       in   1      serial data
//   in_ready     out  1      1 only in HUNT; a bit is consumed when in_valid & in_ready
//   match_valid  out  1      match event pending
//   match_ready  in   1      consumer accepts the event
//   match_pos    out  CNT_W  0-based session index of the bit that completed the match
//   match_cnt    out  MC_W   matches accepted this session
//   busy         out  1      state is HUNT or REPORT
//   done         out  1      one-cycle pulse on session end
//   timeout      out  1      session ended on MAX_BITS; held until next start
// BEHAVIOUR
//   Reset: state=IDLE, pattern=0, history=0, all counters 0, all outputs 0.
//   States: IDLE, HUNT, REPORT, DONE. All outputs are registered or decoded from state.
//   IDLE: cfg_we loads pattern. On start, clear history, fill, bit_idx, match_cnt and timeout;
//     the next state is HUNT.
//   HUNT: each consumed bit sets hist <= {hist[PAT_W-2:0],in_bit}, increments bit_idx, and
//     increments fill (saturates at PAT_W).
//     Match: fill+1>=PAT_W and {hist[PAT_W-2:0],in_bit}==pattern. On the next edge:
//     REPORT, match_valid=1, match_pos=current bit_idx.
//     No match and bit_idx+1==MAX_BITS: DONE, timeout=1.
//   REPORT: match_valid, match_pos and in_ready=0 stay stable until match_ready.
//     On accept: match_cnt++, match_valid=0.
//     If new match_cnt==MAX_MATCH: DONE, timeout=0.
//     Else if bit_idx==MAX_BITS: DONE, timeout=1. A match on the last bit is still reported.
//     Otherwise: HUNT.
//   DONE: done=1 for this single cycle, then IDLE. start in DONE re-arms directly to HUNT.
//   Priority: abort > start > handshake/match. Abort returns to IDLE next cycle: match_valid=0,
//     busy=0, no done pulse, match_cnt retained for readback. Cleared by the next start.
//   cfg_we outside IDLE is ignored; the pattern is never changed mid-session.
//   rst_n low at any point forces the reset values asynchronously. A pending match is discarded.
// CONFIGURATION
//   SEQ_OVERLAP_EN defined: history and fill are kept after a match, so overlapping matches
//     are reported. Example: 1011 in 1011011 matches at positions 3 and 6.
//   SEQ_OVERLAP_EN undefined: history and fill are cleared on match acceptance. The same
//     stream gives one match, at position 3.
// STRUCTURE
//   seq_detect_pkg: state encoding localparams (ST_IDLE..ST_DONE), shared with the
//     seq_detect benches.
//   One sub-module, seq_shift_cmp: history shift register, fill counter and the PAT_W compare.
//     Inputs: shift enable and clear. Output: a combinational hit flag.
// TESTING (PAT_W=4, pattern=4'b1011, MAX_BITS=16, MAX_MATCH=2, match_ready=1 unless stated)
//   1 Reset: rst_n=0, then release -> all outputs 0, in_ready=0, state IDLE.
//   2 start, then stream 1011011. With SEQ_OVERLAP_EN: match_pos 3 then 6, match_cnt=2,
//     done pulse, timeout=0. Without it: one match, pos 3.
//   3 Backpressure: hold match_ready=0 for 5 cycles after a match -> match_valid and match_pos
//     stable, in_ready=0, no bits consumed.
//   4 Timeout: start, then 16 zero bits -> done pulse after the 16th, timeout=1, match_cnt=0.
//   5 Last-bit match: pattern completes at bit 15 -> match reported with pos 15.
//     On accept -> DONE, timeout=1.
//   6 abort during REPORT, and rst_n=0 mid-HUNT -> IDLE next cycle, match_valid=0, done
//     never pulses. cfg_we in HUNT leaves the pattern unchanged.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// rtl/seq_detect_pkg.sv - state encoding and sizing helper shared by seq_detect RTL and benches
package seq_detect_pkg;

    // Session states of the controller.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HUNT   = 2'd1,
        ST_REPORT = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Width of a counter that must hold the values 0..pat_w inclusive.
    function automatic int fill_width(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/seq_shift_cmp.sv
// rtl/seq_shift_cmp.sv - pattern history shift register, fill counter and combinational compare
module seq_shift_cmp
    import seq_detect_pkg::*;
#(
    parameter int PAT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             in_bit,
    input  logic [PAT_W-1:0] pattern,
    output logic             hit
);

    localparam int FILL_W = fill_width(PAT_W);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] FILL_NEAR = FILL_W'(PAT_W - 1);

    // Only the newest PAT_W-1 bits need storing: the incoming bit completes the window.
    logic [PAT_W-2:0]  hist;
    logic [FILL_W-1:0] fill;
    logic [PAT_W-1:0]  window;

    assign window = {hist, in_bit};

    // A hit needs a full window once the incoming bit is counted (fill + 1 >= PAT_W).
    assign hit = (fill >= FILL_NEAR) && (window == pattern);

    // Shift the incoming bit into history and count valid bits, saturating at PAT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= '0;
            fill <= '0;
        end else if (clear) begin
            hist <= '0;
            fill <= '0;
        end else if (shift_en) begin
            hist <= window[PAT_W-2:0];
            if (fill != FILL_FULL) begin
                fill <= fill + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// rtl/seq_detect_ctrl.sv - serial pattern detection session controller (optional SEQ_OVERLAP_EN)
module seq_detect_ctrl
    import seq_detect_pkg::*;
#(
    parameter int  PAT_W     = 4,
    parameter int  MAX_BITS  = 256,
    parameter int  MAX_MATCH = 8,
    localparam int CNT_W     = $clog2(MAX_BITS + 1),
    localparam int MC_W      = $clog2(MAX_MATCH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    output logic             match_valid,
    input  logic             match_ready,
    output logic [CNT_W-1:0] match_pos,
    output logic [MC_W-1:0]  match_cnt,
    output logic             busy,
    output logic             done,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(MAX_BITS - 1);
    localparam logic [CNT_W-1:0] BIT_BUDGET = CNT_W'(MAX_BITS);
    localparam logic [MC_W-1:0]  LAST_MATCH = MC_W'(MAX_MATCH - 1);

    state_t           state;
    state_t           next_state;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] bit_idx;

    logic hit;
    logic arm;
    logic consume;
    logic accept;
    logic last_bit;
    logic final_match;
    logic bits_spent;
    logic shift_clear;

    // Abort outranks everything; start only arms from IDLE or DONE.
    assign arm         = start && !abort && ((state == ST_IDLE) || (state == ST_DONE));
    assign consume     = (state == ST_HUNT) && in_valid && !abort;
    assign accept      = (state == ST_REPORT) && match_ready && !abort;
    assign last_bit    = (bit_idx == LAST_IDX);
    assign final_match = (match_cnt == LAST_MATCH);
    assign bits_spent  = (bit_idx == BIT_BUDGET);

`ifdef SEQ_OVERLAP_EN
    // History survives an accepted match so overlapping occurrences are found.
    assign shift_clear = arm;
`else
    // Each accepted match restarts the window from empty.
    assign shift_clear = arm || accept;
`endif

    seq_shift_cmp #(
        .PAT_W (PAT_W)
    ) u_shift_cmp (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (shift_clear),
        .shift_en (consume),
        .in_bit   (in_bit),
        .pattern  (pattern),
        .hit      (hit)
    );

    // Flags decoded straight from the state register.
    assign in_ready    = (state == ST_HUNT);
    assign match_valid = (state == ST_REPORT);
    assign busy        = (state == ST_HUNT) || (state == ST_REPORT);
    assign done        = (state == ST_DONE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state selection: abort, then start, then bit/handshake progress.
    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        next_state = ST_HUNT;
                    end
                end
                ST_HUNT: begin
                    if (in_valid) begin
                        if (hit) begin
                            next_state = ST_REPORT;
                        end else if (last_bit) begin
                            next_state = ST_DONE;
                        end
                    end
                end
                ST_REPORT: begin
                    if (match_ready) begin
                        if (final_match || bits_spent) begin
                            next_state = ST_DONE;
                        end else begin
                            next_state = ST_HUNT;
                        end
                    end
                end
                ST_DONE: begin
                    next_state = start ? ST_HUNT : ST_IDLE;
                end
                default: begin
                    next_state = ST_IDLE;
                end
            endcase
        end
    end

    // Pattern is writable only while idle so a running session never sees it change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern <= '0;
        end else if (cfg_we && (state == ST_IDLE)) begin
            pattern <= cfg_pattern;
        end
    end

    // Session bit index: cleared on arm, advanced by every consumed bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_idx <= '0;
        end else if (arm) begin
            bit_idx <= '0;
        end else if (consume) begin
            bit_idx <= bit_idx + 1'b1;
        end
    end

    // Capture the index of the bit that completed a match; held through backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_pos <= '0;
        end else if (consume && hit) begin
            match_pos <= bit_idx;
        end
    end

    // Accepted-match count; left intact by abort so software can read it back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_cnt <= '0;
        end else if (arm) begin
            match_cnt <= '0;
        end else if (accept) begin
            match_cnt <= match_cnt + 1'b1;
        end
    end

    // Timeout when the bit budget runs out, whether on a plain bit or after a last-bit match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout <= 1'b0;
        end else if (arm) begin
            timeout <= 1'b0;
        end else if (consume && !hit && last_bit) begin
            timeout <= 1'b1;
        end else if (accept && !final_match && bits_spent) begin
            timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb/tb_seq_detect_ctrl.sv - scoreboard bench for seq_detect_ctrl against a bit-window model
module tb_seq_detect_ctrl;

    localparam int PAT_W     = 4;
    localparam int MAX_BITS  = 16;
    localparam int MAX_MATCH = 2;
    localparam int CNT_W     = $clog2(MAX_BITS + 1);
    localparam int MC_W      = $clog2(MAX_MATCH + 1);

    typedef struct { int pos; int cnt; } match_t;
    typedef struct { int to;  int cnt; } end_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cfg_we = 1'b0;
    logic [PAT_W-1:0] cfg_pattern = '0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_bit = 1'b0;
    logic             match_ready = 1'b0;
    logic             in_ready;
    logic             match_valid;
    logic [CNT_W-1:0] match_pos;
    logic [MC_W-1:0]  match_cnt;
    logic             busy;
    logic             done;
    logic             timeout;

    int checks = 0;
    int passed = 0;

    match_t exp_match[$];
    end_t   exp_end[$];
    bit     stim[$];
    bit     win[$];
    logic [PAT_W-1:0] model_pat = '0;
    int     model_bits;
    int     model_matches;
    int     last_to;
    int     hold_cnt = 0;
    bit     model_ended;
    int     prev_pend = 0;
    logic [CNT_W-1:0] prev_pos = '0;
    match_t mon_m;
    end_t   mon_e;

    seq_detect_ctrl #(
        .PAT_W     (PAT_W),
        .MAX_BITS  (MAX_BITS),
        .MAX_MATCH (MAX_MATCH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .start       (start),
        .abort       (abort),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .in_ready    (in_ready),
        .match_valid (match_valid),
        .match_ready (match_ready),
        .match_pos   (match_pos),
        .match_cnt   (match_cnt),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: actual %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_start();
        model_bits    = 0;
        model_matches = 0;
        model_ended   = 0;
        win.delete();
    endtask

    task automatic end_session(input int to);
        exp_end.push_back('{to, model_matches});
        model_ended = 1;
        last_to     = to;
    endtask

    // Reference: the last PAT_W bits since session start (or since the previous match when
    // overlap is off) must equal the pattern, oldest bit against the pattern MSB.
    task automatic model_consume(input bit b);
        bit h;
        model_bits++;
        win.push_back(b);
        if (win.size() > PAT_W) void'(win.pop_front());
        h = (win.size() == PAT_W);
        if (h) begin
            for (int i = 0; i < PAT_W; i++) begin
                if (win[i] != model_pat[PAT_W-1-i]) h = 0;
            end
        end
        if (h) begin
            exp_match.push_back('{model_bits - 1, model_matches});
            model_matches++;
`ifndef SEQ_OVERLAP_EN
            win.delete();
`endif
        end
        if (h && model_matches == MAX_MATCH) end_session(0);
        else if (model_bits == MAX_BITS) end_session(1);
    endtask

    task automatic set_ready(input int rmode);
        case (rmode)
            0: match_ready = 1'b1;
            1: match_ready = 1'($urandom_range(1));
            default: begin
                if (match_valid && hold_cnt < 5) begin
                    match_ready = 1'b0;
                    hold_cnt++;
                end else begin
                    match_ready = 1'b1;
                    if (!match_valid) hold_cnt = 0;
                end
            end
        endcase
    endtask

    task automatic set_stim(input logic [31:0] v, input int n);
        stim.delete();
        for (int i = n - 1; i >= 0; i--) stim.push_back(v[i]);
    endtask

    task automatic load_pattern(input logic [PAT_W-1:0] p);
        cfg_we = 1'b1;
        cfg_pattern = p;
        tick();
        cfg_we = 1'b0;
        model_pat = p;
    endtask

    task automatic feed(input int vprob, input int rmode);
        int idx = 0;
        int guard = 0;
        while (!model_ended && idx < stim.size() && guard < 500) begin
            guard++;
            set_ready(rmode);
            in_valid = ($urandom_range(99) < vprob);
            in_bit = stim[idx];
            if (in_valid && in_ready) begin
                model_consume(in_bit);
                idx++;
            end
            tick();
        end
        in_valid = 1'b0;
        check("feed_bound", int'(guard < 500), 1);
    endtask

    task automatic drain(input int rmode);
        int guard = 0;
        while ((exp_match.size() != 0 || exp_end.size() != 0) && guard < 200) begin
            guard++;
            set_ready(rmode);
            tick();
        end
        check("drain_bound", int'(guard < 200), 1);
        exp_match.delete();
        exp_end.delete();
    endtask

    task automatic close_session();
        if (model_ended) begin
            check("timeout_held", timeout, last_to);
            check("idle_after_done", busy, 0);
        end else begin
            abort = 1'b1;
            tick();
            abort = 1'b0;
            exp_match.delete();
            exp_end.delete();
            check("abort_busy", busy, 0);
            check("abort_valid", match_valid, 0);
            check("abort_cnt_kept", match_cnt, model_matches);
        end
    endtask

    task automatic run_session(input logic [PAT_W-1:0] pat, input int vprob, input int rmode,
                               input bit poke_cfg);
        load_pattern(pat);
        model_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        if (poke_cfg) begin
            cfg_we = 1'b1;
            cfg_pattern = ~pat;
            tick();
            cfg_we = 1'b0;
        end
        feed(vprob, rmode);
        drain(rmode);
        close_session();
    endtask

    // Monitor: pops expectations on every accepted match and every done pulse.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_pend = 0;
        end else begin
            if (match_valid) begin
                check("no_in_ready_in_report", in_ready, 0);
                if (prev_pend != 0) check("match_pos_stable", match_pos, prev_pos);
                if (match_ready && !abort) begin
                    check("match_expected", int'(exp_match.size() != 0), 1);
                    if (exp_match.size() != 0) begin
                        mon_m = exp_match.pop_front();
                        check("match_pos", match_pos, mon_m.pos);
                        check("match_cnt_before_accept", match_cnt, mon_m.cnt);
                    end
                    prev_pend = 0;
                end else begin
                    prev_pend = abort ? 0 : 1;
                    prev_pos  = match_pos;
                end
            end else begin
                prev_pend = 0;
            end
            if (done) begin
                check("done_expected", int'(exp_end.size() != 0), 1);
                if (exp_end.size() != 0) begin
                    mon_e = exp_end.pop_front();
                    check("done_timeout", timeout, mon_e.to);
                    check("done_match_cnt", match_cnt, mon_e.cnt);
                    check("done_not_busy", busy, 0);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        tick();
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_match_valid", match_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_timeout", timeout, 0);
        check("rst_match_pos", match_pos, 0);
        check("rst_match_cnt", match_cnt, 0);
        rst_n = 1'b1;
        tick();
        check("idle_in_ready", in_ready, 0);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);

        // 1011011 with a pattern write attempted mid-session
        set_stim(32'b1011011, 7);
        run_session(4'b1011, 100, 0, 1);

        // backpressure of five cycles per match
        set_stim(32'b10111011, 8);
        run_session(4'b1011, 100, 2, 0);

        // bit budget exhausted with no match
        set_stim(32'h0, 16);
        run_session(4'b1011, 100, 0, 0);
        check("timeout_cnt_zero", match_cnt, 0);

        // match completing on the final budgeted bit
        set_stim(32'b0000_0000_0000_1011, 16);
        run_session(4'b1011, 100, 0, 0);
        check("last_bit_timeout", timeout, 1);

        // abort while the second match is held pending
        load_pattern(4'b1011);
        model_start();
        set_stim(32'b10111011, 8);
        start = 1'b1;
        tick();
        start = 1'b0;
        feed(100, 0);
        match_ready = 1'b0;
        repeat (3) tick();
        check("abort_pending_valid", match_valid, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        exp_match.delete();
        exp_end.delete();
        check("abort_report_valid", match_valid, 0);
        check("abort_report_busy", busy, 0);
        check("abort_report_cnt", match_cnt, 1);
        repeat (3) tick();

        // reset mid-hunt
        load_pattern(4'b1011);
        model_start();
        set_stim(32'b101, 3);
        start = 1'b1;
        tick();
        start = 1'b0;
        feed(100, 0);
        check("hunt_before_reset", busy, 1);
        rst_n = 1'b0;
        #2;
        check("async_rst_busy", busy, 0);
        check("async_rst_in_ready", in_ready, 0);
        check("async_rst_match_pos", match_pos, 0);
        tick();
        rst_n = 1'b1;
        exp_match.delete();
        exp_end.delete();
        model_pat = '0;
        tick();
        check("post_rst_busy", busy, 0);
        check("post_rst_done", done, 0);

        // randomized sessions
        for (int s = 0; s < 40; s++) begin
            n = int'($urandom_range(20, 4));
            stim.delete();
            for (int i = 0; i < n; i++) stim.push_back(1'($urandom_range(1)));
            run_session(PAT_W'($urandom), int'($urandom_range(100, 40)),
                        int'($urandom_range(2)), 1'($urandom_range(1)));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
